// File: rtl/stopwatch_controller.sv
// Stopwatch control FSM: debounces three keys, gates the tenths tick into the timer chain,
// and muxes live or lap-held digits to the display. Optional blink: `define STOPWATCH_BLINK_EN.
module stopwatch_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_TICKS     = 5
) (
  input  logic       CLOCK_50,
  input  logic       resetN,
  input  logic       keyStartStopN,
  input  logic       keyLapN,
  input  logic       keyClearN,
  input  logic       tenthTick,
  input  logic [3:0] curMinutes,
  input  logic [2:0] curSecondTens,
  input  logic [3:0] curSecondOnes,
  input  logic [3:0] curTenths,
  output logic       gatedTick,
  output logic       timerClear,
  output logic [3:0] dispMinutes,
  output logic [2:0] dispSecondTens,
  output logic [3:0] dispSecondOnes,
  output logic [3:0] dispTenths,
  output logic       dispBlank,
  output logic [2:0] state,
  output logic       expired,
  output logic       lapActive
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RUNNING  = 3'd1;
  localparam logic [2:0] LAP_HOLD = 3'd2;
  localparam logic [2:0] PAUSED   = 3'd3;
  localparam logic [2:0] EXPIRED  = 3'd4;

  localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Key index: 0 = startStop, 1 = lap, 2 = clear.
  logic [2:0]       rawKeys;
  logic [2:0]       syncA, syncB, keyLevel, keyLevelQ;
  logic [CNT_W-1:0] debCnt [3];
  logic [2:0]       pressEv;

  assign rawKeys = {keyClearN, keyLapN, keyStartStopN};

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50 or negedge resetN) begin
    if (!resetN) begin
      syncA     <= '1;
      syncB     <= '1;
      keyLevel  <= '1;
      keyLevelQ <= '1;
      // NOTE: small counter arrays are reset element by element; they are flops, not RAM.
      for (int k = 0; k < 3; k++) debCnt[k] <= '0;
    end else begin
      syncA     <= rawKeys;
      syncB     <= syncA;
      keyLevelQ <= keyLevel;
      for (int k = 0; k < 3; k++) begin
        if (syncB[k] == keyLevel[k]) begin
          debCnt[k] <= '0;
        end else if (debCnt[k] == CNT_LAST) begin
          keyLevel[k] <= syncB[k];
          debCnt[k]   <= '0;
        end else begin
          debCnt[k] <= debCnt[k] + 1'b1;
        end
      end
    end
  end

  assign pressEv = keyLevelQ & ~keyLevel;

  logic clearEv, startStopEv, lapEv, atMax, expireNow, latchLap;
  logic [2:0]  nextState;
  logic [14:0] holdDigits, curDigits;

  assign clearEv     = pressEv[2];
  assign startStopEv = pressEv[0] && !pressEv[2];
  assign lapEv       = pressEv[1] && !pressEv[0] && !pressEv[2];

  assign atMax = (curMinutes == 4'd9) && (curSecondTens == 3'd5) &&
                 (curSecondOnes == 4'd9) && (curTenths == 4'd9);
  assign expireNow = tenthTick && atMax;

  // NOTE: defaults at the top of always_comb keep every path assigned, so no latches.
  always_comb begin
    nextState = state;
    latchLap  = 1'b0;
    case (state)
      IDLE:     if (startStopEv) nextState = RUNNING;
      RUNNING: begin
        if (expireNow)        nextState = EXPIRED;
        else if (startStopEv) nextState = PAUSED;
        else if (lapEv) begin
          nextState = LAP_HOLD;
          latchLap  = 1'b1;
        end
      end
      LAP_HOLD: begin
        if (expireNow)        nextState = EXPIRED;
        else if (lapEv)       nextState = RUNNING;
        else if (startStopEv) nextState = PAUSED;
      end
      PAUSED: begin
        if (startStopEv)  nextState = RUNNING;
        else if (clearEv) nextState = IDLE;
      end
      EXPIRED:  if (clearEv) nextState = IDLE;
      default:  nextState = IDLE;
    endcase
  end

  assign curDigits = {curMinutes, curSecondTens, curSecondOnes, curTenths};

  always_ff @(posedge CLOCK_50 or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      holdDigits <= '0;
    end else begin
      state <= nextState;
      if (latchLap) holdDigits <= curDigits;
    end
  end

  assign timerClear = (state == IDLE);
  assign expired    = (state == EXPIRED);
  assign lapActive  = (state == LAP_HOLD);
  assign gatedTick  = tenthTick && ((state == RUNNING) || (state == LAP_HOLD)) && !atMax;

  assign {dispMinutes, dispSecondTens, dispSecondOnes, dispTenths} =
      lapActive ? holdDigits : curDigits;

`ifdef STOPWATCH_BLINK_EN
  localparam int               BLINK_W    = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

  logic [BLINK_W-1:0] blinkCnt;
  logic               blinkPhase;

  // Counts raw ticks, so the blink rate holds even while the timer itself is frozen.
  always_ff @(posedge CLOCK_50 or negedge resetN) begin
    if (!resetN) begin
      blinkCnt   <= '0;
      blinkPhase <= 1'b0;
    end else if (nextState != state) begin
      blinkCnt   <= '0;
      blinkPhase <= 1'b0;
    end else if (((state == PAUSED) || (state == EXPIRED)) && tenthTick) begin
      if (blinkCnt == BLINK_LAST) begin
        blinkCnt   <= '0;
        blinkPhase <= ~blinkPhase;
      end else begin
        blinkCnt <= blinkCnt + 1'b1;
      end
    end
  end

  assign dispBlank = blinkPhase;
`else
  assign dispBlank = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_controller.sv
// Self-checking bench for stopwatch_controller; the bench also plays the role of the timer chain.
// The reference model works on key-sample histories and a tenths count rather than RTL registers.
module tb_stopwatch_controller;
  localparam int DEB = 4;
  localparam int BLK = 2;
  localparam int MAX_TENTHS = 5999;

  logic CLOCK_50 = 1'b0;
  logic resetN = 1'b1;
  logic [2:0] rawN = 3'b111;
  logic tenthTick = 1'b0;
  logic [3:0] curMinutes, curSecondOnes, curTenths;
  logic [2:0] curSecondTens;
  logic gatedTick, timerClear, dispBlank, expired, lapActive;
  logic [3:0] dispMinutes, dispSecondOnes, dispTenths;
  logic [2:0] dispSecondTens, state;

  always #5 CLOCK_50 = ~CLOCK_50;

  stopwatch_controller #(.DEBOUNCE_CYCLES(DEB), .BLINK_TICKS(BLK)) dut (
    .CLOCK_50(CLOCK_50), .resetN(resetN),
    .keyStartStopN(rawN[0]), .keyLapN(rawN[1]), .keyClearN(rawN[2]),
    .tenthTick(tenthTick),
    .curMinutes(curMinutes), .curSecondTens(curSecondTens),
    .curSecondOnes(curSecondOnes), .curTenths(curTenths),
    .gatedTick(gatedTick), .timerClear(timerClear),
    .dispMinutes(dispMinutes), .dispSecondTens(dispSecondTens),
    .dispSecondOnes(dispSecondOnes), .dispTenths(dispTenths),
    .dispBlank(dispBlank), .state(state), .expired(expired), .lapActive(lapActive)
  );

  // Timer chain stand-in: elapsed time held as a plain count of tenths.
  int timerVal = 0;

  function automatic logic [14:0] digits(input int v);
    return {4'(v / 600), 3'((v / 100) % 6), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  always_comb {curMinutes, curSecondTens, curSecondOnes, curTenths} = digits(timerVal);

  // Reference model state (0 idle, 1 running, 2 lap hold, 3 paused, 4 expired).
  int mState, holdVal, blinkTicks;
  bit db [3];
  bit ev [3];
  bit d0 [3];
  bit d1 [3];
  logic [DEB-1:0] win [3];

  int vectors = 0, miscompares = 0;
  int tickMode = 0, tickPhase = 0, gatedSeen = 0;

  task automatic chk(input string name, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic modelReset();
    mState = 0; holdVal = 0; blinkTicks = 0;
    for (int k = 0; k < 3; k++) begin
      db[k] = 1'b1; ev[k] = 1'b0; d0[k] = 1'b1; d1[k] = 1'b1; win[k] = '1;
    end
  endtask

  // One clock edge of the model, using the inputs that were present before the edge.
  task automatic modelEdge();
    bit tick, atMax, gated, seen;
    int old, winner;
    tick  = tenthTick;
    atMax = (timerVal == MAX_TENTHS);
    old   = mState;
    gated = tick && (old == 1 || old == 2) && !atMax;
    winner = ev[2] ? 2 : ev[0] ? 0 : ev[1] ? 1 : -1;
    case (old)
      0: if (winner == 0) mState = 1;
      1: if (tick && atMax) mState = 4;
         else if (winner == 0) mState = 3;
         else if (winner == 1) begin mState = 2; holdVal = timerVal; end
      2: if (tick && atMax) mState = 4;
         else if (winner == 1) mState = 1;
         else if (winner == 0) mState = 3;
      3: if (winner == 0) mState = 1; else if (winner == 2) mState = 0;
      4: if (winner == 2) mState = 0;
      default: mState = 0;
    endcase
    if (old == 0) timerVal = 0;
    else if (gated) timerVal++;
    if (mState != old) blinkTicks = 0;
    else if ((old == 3 || old == 4) && tick) blinkTicks++;
    // A key level is accepted once the 2-cycle-delayed raw key has disagreed with it DEB times running.
    for (int k = 0; k < 3; k++) begin
      seen  = d1[k];
      d1[k] = d0[k];
      d0[k] = rawN[k];
      win[k] = {win[k][DEB-2:0], seen};
      ev[k] = 1'b0;
      if (db[k] ? (win[k] == '0) : (win[k] == '1)) begin
        db[k] = ~db[k];
        ev[k] = ~db[k];
      end
    end
  endtask

  task automatic checkOutputs(input string tag);
    bit expBlank;
    bit atMax;
    atMax = (timerVal == MAX_TENTHS);
`ifdef STOPWATCH_BLINK_EN
    expBlank = ((blinkTicks / BLK) % 2) == 1;
`else
    expBlank = 1'b0;
`endif
    chk({tag, "/state"}, 16'(state), 16'(mState));
    chk({tag, "/timerClear"}, 16'(timerClear), 16'(mState == 0));
    chk({tag, "/expired"}, 16'(expired), 16'(mState == 4));
    chk({tag, "/lapActive"}, 16'(lapActive), 16'(mState == 2));
    chk({tag, "/gatedTick"}, 16'(gatedTick), 16'(tenthTick && (mState == 1 || mState == 2) && !atMax));
    chk({tag, "/disp"}, 16'({dispMinutes, dispSecondTens, dispSecondOnes, dispTenths}),
        16'(digits(mState == 2 ? holdVal : timerVal)));
    chk({tag, "/dispBlank"}, 16'(dispBlank), 16'(expBlank));
    if (gatedTick === 1'b1) gatedSeen++;
  endtask

  // Drive the tick for this cycle, check mid-cycle, then step the model after the edge.
  task automatic cycle(input string tag);
    if (tickMode == 0) tenthTick = 1'b0;
    else if (tickMode == 1) tenthTick = ($urandom_range(2) == 0);
    else tenthTick = ((tickPhase % tickMode) == 0);
    tickPhase++;
    #1;
    checkOutputs(tag);
    @(posedge CLOCK_50);
    #1;
    modelEdge();
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic press(input string tag, input logic [2:0] mask, input int holdCycles, input bit bounce);
    if (bounce)
      for (int i = 0; i < 20; i++) begin
        rawN = ((i / 2) % 2 == 0) ? (rawN & ~mask) : (rawN | mask);
        cycle(tag);
      end
    rawN = rawN & ~mask;
    run(tag, holdCycles);
    rawN = rawN | mask;
    run(tag, 9);
  endtask

  task automatic applyReset(input string tag);
    resetN = 1'b0;
    #1;
    modelReset();
    checkOutputs(tag);
    @(posedge CLOCK_50);
    #1;
    checkOutputs(tag);
    resetN = 1'b1;
  endtask

  initial begin
    int lat;
    #1;
    applyReset("init");

    // Idle: nothing moves, timer held clear.
    tickMode = 3;
    run("idle", 12);

    // Start: fixed key-to-state latency of DEBOUNCE_CYCLES+3, then three forwarded ticks.
    tickMode = 0;
    lat = 0;
    rawN[0] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cycle("start");
      if (state === 3'd1 && lat == 0) lat = i;
      if (i == 10) rawN[0] = 1'b1;
    end
    chk("start_latency", 16'(lat), 16'd7);
    gatedSeen = 0;
    tickMode = 2; tickPhase = 0;
    run("ticks", 6);
    chk("gated_count", 16'(gatedSeen), 16'd3);
    chk("running_noclear", 16'(timerClear), 16'd0);

    // Lap hold freezes the display while the timer keeps going.
    tickMode = 0;
    timerVal = 123;
    press("lap1", 3'b010, 10, 1'b0);
    timerVal = 150;
    cycle("lap_hold");
    chk("lap_disp", 16'({dispMinutes, dispSecondTens, dispSecondOnes, dispTenths}), 16'(digits(123)));
    chk("lap_active", 16'(lapActive), 16'd1);
    press("lap2", 3'b010, 10, 1'b0);
    chk("lap_release_disp", 16'({dispMinutes, dispSecondTens, dispSecondOnes, dispTenths}), 16'(digits(150)));

    // Bouncing key gives one event (running -> paused); clear beats startStop in paused.
    press("bounce", 3'b001, 10, 1'b1);
    chk("bounce_paused", 16'(state), 16'd3);
    press("clr_ss", 3'b101, 10, 1'b0);
    chk("clear_wins", 16'(state), 16'd0);

    // Expiry at 9:59.9.
    press("start2", 3'b001, 10, 1'b0);
    timerVal = MAX_TENTHS;
    tickMode = 2; tickPhase = 0;
    cycle("at_max");
    chk("expired_state", 16'(state), 16'd4);
    chk("expired_flag", 16'(expired), 16'd1);
    press("exp_ss", 3'b001, 10, 1'b0);
    chk("exp_ignores_ss", 16'(state), 16'd4);
    press("exp_clr", 3'b100, 10, 1'b0);
    chk("exp_cleared", 16'(state), 16'd0);

    // Reset in the middle of a lap hold, then blink while paused.
    tickMode = 0;
    press("start3", 3'b001, 10, 1'b0);
    timerVal = 321;
    press("lap3", 3'b010, 10, 1'b0);
    timerVal = 77;
    applyReset("reset_lap");
    chk("reset_disp_live", 16'({dispMinutes, dispSecondTens, dispSecondOnes, dispTenths}), 16'(digits(77)));
    press("start4", 3'b001, 10, 1'b0);
    press("pause4", 3'b001, 10, 1'b0);
    tickMode = 1;
    run("blink", 20);

    // Randomized key traffic with random ticks, occasional near-max time and resets.
    for (int n = 0; n < 150; n++) begin
      logic [2:0] mask;
      mask = 3'($urandom_range(1, 7));
      if ($urandom_range(9) == 0) timerVal = MAX_TENTHS - int'($urandom_range(5));
      if ($urandom_range(39) == 0) applyReset("rnd_reset");
      press("rnd", mask, $urandom_range(2, 12), $urandom_range(4) == 0);
      run("rnd_idle", $urandom_range(0, 6));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/stopwatch_controller.md
Name: stopwatch_controller

Overview:
Control FSM that sequences the tenths-driven ten-minute timer chain as a stopwatch with start/stop, lap-hold and clear keys. It debounces three raw active-low pushbuttons and gates the tenths tick into the timer. It drives the timer clear and muxes live or lap-frozen digits to the display. Sits between secondTenthsTimer/KEY inputs and tenMinTimer/7-segment decoders.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive CLOCK_50 cycles a synchronized key level must hold before it is accepted (10 ms at 50 MHz).
BLINK_TICKS, 5, tenthTick count per half-period of display blink (used only with the optional feature).

Ports:
CLOCK_50  input  1  system clock; all state updates on rising edge
resetN  input  1  asynchronous, active-low reset
keyStartStopN  input  1  raw pushbutton, 0 = pressed
keyLapN  input  1  raw pushbutton, 0 = pressed
keyClearN  input  1  raw pushbutton, 0 = pressed
tenthTick  input  1  one-cycle pulse every 0.1 s from the tenths generator
curMinutes  input  4  live timer minutes (0-9)
curSecondTens  input  3  live timer seconds tens (0-5)
curSecondOnes  input  4  live timer seconds ones (0-9)
curTenths  input  4  live timer tenths (0-9)
gatedTick  output  1  tick forwarded to the timer
timerClear  output  1  synchronous clear request to the timer
dispMinutes  output  4  displayed minutes
dispSecondTens  output  3  displayed seconds tens
dispSecondOnes  output  4  displayed seconds ones
dispTenths  output  4  displayed tenths
dispBlank  output  1  1 = display digits off
state  output  3  IDLE=0, RUNNING=1, LAP_HOLD=2, PAUSED=3, EXPIRED=4
expired  output  1  1 while in EXPIRED
lapActive  output  1  1 while in LAP_HOLD

Behaviour:
- Reset (resetN=0, asynchronous): state=IDLE; lap hold registers=0; debounced key levels=1 (released); blink counter/phase=0; dispBlank=0; expired=0; lapActive=0.
- Key path: 2-flop synchronizer, then a counter that accepts the new level after DEBOUNCE_CYCLES consecutive equal samples. A press event is a one-cycle pulse on a debounced 1->0 transition. A key held through reset release produces one event. Latency from raw edge to state change is DEBOUNCE_CYCLES+3 cycles.
- Same-cycle events: priority clear > startStop > lap. Only the winning event acts; the others are dropped.
- atMax = (curMinutes==9 && curSecondTens==5 && curSecondOnes==9 && curTenths==9).
- gatedTick = tenthTick && (state==RUNNING || state==LAP_HOLD) && !atMax. Combinational, so there is zero-cycle tick latency.
- timerClear = 1 whenever state==IDLE (registered state decode).
- IDLE: startStop -> RUNNING. Lap and clear are ignored.
- RUNNING: startStop -> PAUSED. Lap -> LAP_HOLD, latching the cur* values of that cycle into the hold registers. Clear is ignored. tenthTick && atMax -> EXPIRED.
- LAP_HOLD: the timer keeps counting and disp* show the hold registers. Lap -> RUNNING. startStop -> PAUSED. Clear is ignored. tenthTick && atMax -> EXPIRED.
- PAUSED: startStop -> RUNNING. Clear -> IDLE. Lap is ignored.
- EXPIRED: the timer is frozen at 9:59.9. Clear -> IDLE. startStop and lap are ignored.
- Display: disp* = hold registers in LAP_HOLD, otherwise cur* (combinational pass-through).
- Unused encodings 5-7 recover to IDLE on the next clock.

Optional Feature:
STOPWATCH_BLINK_EN
- Defined: in PAUSED and EXPIRED, a counter of ungated tenthTick toggles the blink phase every BLINK_TICKS ticks, and dispBlank = phase. Phase and counter clear to 0 on entry to any state.
- Undefined: dispBlank is tied to 0, and the blink logic and the BLINK_TICKS usage are absent.

Test Plan:
All scenarios run with DEBOUNCE_CYCLES=4 and BLINK_TICKS=2.
1. Release reset, apply no keys -> state=0, timerClear=1, gatedTick=0 on every tenthTick, dispBlank=0.
2. Press startStop for 10 cycles, then apply 3 tenthTicks -> state=1 exactly 7 cycles after the press edge, gatedTick pulses 3 times, timerClear=0.
3. While RUNNING with cur*=0:12.3, press lap; timer advances to 0:15.0 -> state=2, lapActive=1, disp*=0:12.3. Press lap again -> state=1, disp*=0:15.0.
4. Bounce keyStartStopN 0/1 every 2 cycles for 20 cycles, then hold 0 -> exactly one event. Press clear and startStop together in PAUSED -> state=0.
5. RUNNING with cur*=9:59.9, apply tenthTick -> gatedTick=0 that cycle, state=4 next cycle, expired=1. startStop is ignored; clear -> state=0.
6. Assert resetN=0 mid-LAP_HOLD -> state=0, lapActive=0, disp* follow cur* immediately. With STOPWATCH_BLINK_EN in PAUSED, dispBlank toggles every 2 tenthTicks.
